// File: rtl/saa_pkg.sv
// Shared definitions for the SAA7111-compatible pixel-bus generator.
// Holds the RGB565 colour constants used by the colour-bar pattern, the
// pattern_sel encodings, and a helper that maps a bar index to its colour.
package saa_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_e;

    // RGB565 {R[4:0],G[5:0],B[4:0]}
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/saa_timing_cnt.sv
// Line/field timing for the pixel-bus generator.
// Ports:
//   clk_i          pixel clock (rising edge)
//   rst_i          synchronous active-high reset
//   en_i           count enable; low parks both counters at h=0,v=0
//   href_act_o     current h position is inside the active line
//   vref_act_o     current v position is inside the active field
//   field_start_o  current position is h=0,v=0
//   bar_idx_o      colour-bar index for the current h position
//   ramp_g_o       low 8 bits of h, used as the gray-ramp level
//   check_o        checkerboard cell colour for the current (h,v)
module saa_timing_cnt #(
    parameter int H_ACTIVE = 720,
    parameter int H_TOTAL  = 858,
    parameter int V_ACTIVE = 240,
    parameter int V_TOTAL  = 262
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       href_act_o,
    output logic       vref_act_o,
    output logic       field_start_o,
    output logic [2:0] bar_idx_o,
    output logic [7:0] ramp_g_o,
    output logic       check_o
);

    // Counters are kept at least 8 (h) / 4 (v) bits wide so the ramp and
    // checkerboard bit selects are always legal, even for tiny test timings.
    localparam int HW    = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
    localparam int VW    = ($clog2(V_TOTAL) < 4) ? 4 : $clog2(V_TOTAL);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_px_q, bar_px_d;
    logic [2:0]    bar_idx_q, bar_idx_d;

    // The bar counter tracks h_cnt: it restarts whenever h returns to 0 and
    // steps the bar index every BAR_W pixels, avoiding a divider on h_cnt.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (!en_i) begin
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d   = '0;
            bar_px_d  = '0;
            bar_idx_d = '0;
            v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
            if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign href_act_o    = (h_cnt_q < H_ACT);
    assign vref_act_o    = (v_cnt_q < V_ACT);
    assign field_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign bar_idx_o     = bar_idx_q;
    assign ramp_g_o      = h_cnt_q[7:0];
    assign check_o       = h_cnt_q[3] ^ v_cnt_q[3];

endmodule

// File: rtl/saa_vpo_gen.sv
// SAA7111-style pixel-bus transmitter: generates HREF/VREF line and field
// strobes and an RGB565 test pattern on VPO, for exercising capture logic
// without a camera or decoder.
// Ports:
//   llc          pixel clock, rising edge
//   rst          synchronous active-high reset
//   en           generator enable; low forces idle outputs (frame_cnt held)
//   pattern_sel  0 bars, 1 gray ramp, 2 checkerboard, 3 solid
//   solid_rgb    RGB565 colour for the solid pattern
//   HREF, VREF   line-active / field-active strobes
//   VPO          RGB565 pixel, zero outside HREF&VREF
//   frame_start  one-cycle pulse with the first active pixel of a field
//   frame_cnt    fields generated, wraps 255->0
module saa_vpo_gen
    import saa_pkg::*;
#(
    parameter int H_ACTIVE = 720,
    parameter int H_TOTAL  = 858,
    parameter int V_ACTIVE = 240,
    parameter int V_TOTAL  = 262
) (
    input  logic        llc,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        HREF,
    output logic        VREF,
    output logic [15:0] VPO,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    logic       href_act;
    logic       vref_act;
    logic       field_start;
    logic [2:0] bar_idx;
    logic [7:0] ramp_g;
    logic       check;

    saa_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_timing (
        .clk_i         (llc),
        .rst_i         (rst),
        .en_i          (en),
        .href_act_o    (href_act),
        .vref_act_o    (vref_act),
        .field_start_o (field_start),
        .bar_idx_o     (bar_idx),
        .ramp_g_o      (ramp_g),
        .check_o       (check)
    );

    pat_e        pat_q, pat_d;
    pat_e        eff_pat;
    logic [15:0] pixel;

    logic        href_q, href_d;
    logic        vref_q, vref_d;
    logic [15:0] vpo_q, vpo_d;
    logic        fs_q, fs_d;
    logic [7:0]  fcnt_q, fcnt_d;

    // The pattern is captured at h=0,v=0; the first pixel of the field must
    // already use the newly selected pattern, so bypass the latch there.
    assign eff_pat = field_start ? pat_e'(pattern_sel) : pat_q;

    always_comb begin
        case (eff_pat)
            PAT_BARS:  pixel = bar_colour(bar_idx);
            PAT_RAMP:  pixel = {ramp_g[7:3], ramp_g[7:2], ramp_g[7:3]};
            PAT_CHECK: pixel = check ? RGB_WHITE : RGB_BLACK;
            PAT_SOLID: pixel = solid_rgb;
            default:   pixel = RGB_BLACK;
        endcase
    end

    always_comb begin
        pat_d  = pat_q;
        href_d = 1'b0;
        vref_d = 1'b0;
        vpo_d  = 16'h0000;
        fs_d   = 1'b0;
        fcnt_d = fcnt_q;
        if (en) begin
            if (field_start) begin
                pat_d  = pat_e'(pattern_sel);
                fcnt_d = fcnt_q + 8'd1;
            end
            href_d = href_act;
            vref_d = vref_act;
            vpo_d  = (href_act && vref_act) ? pixel : 16'h0000;
            fs_d   = field_start;
        end
    end

    always_ff @(posedge llc) begin
        if (rst) begin
            pat_q  <= PAT_BARS;
            href_q <= 1'b0;
            vref_q <= 1'b0;
            vpo_q  <= 16'h0000;
            fs_q   <= 1'b0;
            fcnt_q <= 8'h00;
        end else begin
            pat_q  <= pat_d;
            href_q <= href_d;
            vref_q <= vref_d;
            vpo_q  <= vpo_d;
            fs_q   <= fs_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign HREF        = href_q;
    assign VREF        = vref_q;
    assign VPO         = vpo_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_saa_vpo_gen.sv
module tb_saa_vpo_gen;

    localparam int HA = 8;
    localparam int HT = 12;
    localparam int VA = 4;
    localparam int VT = 6;

    logic        llc = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_rgb;
    logic        HREF;
    logic        VREF;
    logic [15:0] VPO;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    saa_vpo_gen #(
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT)
    ) dut (
        .llc         (llc),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .HREF        (HREF),
        .VREF        (VREF),
        .VPO         (VPO),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 llc = ~llc;

    int total = 0;
    int bad   = 0;

    // model state: mk = cycles since counting (re)started at h=0,v=0
    int         mk;
    logic [1:0] mpat;
    logic [7:0] mfcnt;
    int         fs_count;

    logic [15:0] bar_tbl [8];

    typedef struct {
        logic [1:0]  pat;
        logic [15:0] solid;
        int          px;
        logic [15:0] exp_vpo;
        logic        exp_href;
    } vec_t;

    vec_t vecs [17];

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input logic [1:0] p, input logic [15:0] s,
                                              input int h, input int v);
        logic [7:0] g;
        logic [15:0] r;
        g = 8'(h);
        case (p)
            2'd0:    r = bar_tbl[h / (HA / 8)];
            2'd1:    r = {g[7:3], g[7:2], g[7:3]};
            2'd2:    r = (((h >> 3) ^ (v >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            default: r = s;
        endcase
        return r;
    endfunction

    // Called at a negedge; leaves rst released so the next posedge counts h=0,v=0.
    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge llc);
        @(negedge llc);
        chk1("rst HREF", HREF, 1'b0);
        chk1("rst VREF", VREF, 1'b0);
        chk16("rst VPO", VPO, 16'h0000);
        chk1("rst frame_start", frame_start, 1'b0);
        chk16("rst frame_cnt", {8'h00, frame_cnt}, 16'h0000);
        rst   = 1'b0;
        mk    = 0;
        mfcnt = 8'h00;
    endtask

    task automatic run_model(input int n);
        int h;
        int v;
        logic act;
        logic [15:0] ev;
        for (int i = 0; i < n; i++) begin
            @(posedge llc);
            @(negedge llc);
            h = mk % HT;
            v = (mk / HT) % VT;
            if (h == 0 && v == 0) begin
                mpat  = pattern_sel;
                mfcnt = mfcnt + 8'd1;
            end
            act = (h < HA) && (v < VA);
            ev  = act ? model_pix(mpat, solid_rgb, h, v) : 16'h0000;
            chk1($sformatf("HREF k=%0d", mk), HREF, h < HA);
            chk1($sformatf("VREF k=%0d", mk), VREF, v < VA);
            chk16($sformatf("VPO k=%0d", mk), VPO, ev);
            chk1($sformatf("frame_start k=%0d", mk), frame_start, (h == 0 && v == 0));
            chk16($sformatf("frame_cnt k=%0d", mk), {8'h00, frame_cnt}, {8'h00, mfcnt});
            if (frame_start) fs_count++;
            mk++;
        end
    endtask

    initial begin
        logic [7:0] held;

        bar_tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                    16'hF81F, 16'hF800, 16'h001F, 16'h0000};

        vecs = '{
            '{2'd0, 16'h0000,  0, 16'hFFFF, 1'b1},
            '{2'd0, 16'h0000,  1, 16'hFFE0, 1'b1},
            '{2'd0, 16'h0000,  2, 16'h07FF, 1'b1},
            '{2'd0, 16'h0000,  3, 16'h07E0, 1'b1},
            '{2'd0, 16'h0000,  4, 16'hF81F, 1'b1},
            '{2'd0, 16'h0000,  5, 16'hF800, 1'b1},
            '{2'd0, 16'h0000,  6, 16'h001F, 1'b1},
            '{2'd0, 16'h0000,  7, 16'h0000, 1'b1},
            '{2'd0, 16'h0000,  8, 16'h0000, 1'b0},
            '{2'd0, 16'h0000, 11, 16'h0000, 1'b0},
            '{2'd1, 16'h0000,  3, 16'h0000, 1'b1},
            '{2'd1, 16'h0000,  4, 16'h0020, 1'b1},
            '{2'd1, 16'h0000,  7, 16'h0020, 1'b1},
            '{2'd2, 16'h0000,  5, 16'h0000, 1'b1},
            '{2'd3, 16'h1234,  0, 16'h1234, 1'b1},
            '{2'd3, 16'h1234,  7, 16'h1234, 1'b1},
            '{2'd3, 16'h1234,  9, 16'h0000, 1'b0}
        };

        rst         = 1'b1;
        en          = 1'b1;
        pattern_sel = 2'd0;
        solid_rgb   = 16'h0000;
        mpat        = 2'd0;
        fs_count    = 0;
        @(negedge llc);

        // directed single-pixel vectors on line 0 after reset
        for (int i = 0; i < 17; i++) begin
            pattern_sel = vecs[i].pat;
            solid_rgb   = vecs[i].solid;
            reset_dut();
            repeat (vecs[i].px + 1) @(posedge llc);
            @(negedge llc);
            chk16($sformatf("vec%0d VPO", i), VPO, vecs[i].exp_vpo);
            chk1($sformatf("vec%0d HREF", i), HREF, vecs[i].exp_href);
        end

        // two full fields of colour bars: strobe timing and period
        pattern_sel = 2'd0;
        reset_dut();
        run_model(2 * HT * VT);

        // solid colour, then switch to ramp mid-field
        pattern_sel = 2'd3;
        solid_rgb   = 16'h1234;
        reset_dut();
        run_model(20);
        pattern_sel = 2'd1;
        run_model(100);

        // 256 fields: frame_cnt wraps and one frame_start per field
        pattern_sel = 2'd2;
        reset_dut();
        fs_count = 0;
        run_model(256 * HT * VT);
        chk16("fs count 256 fields", 16'(fs_count), 16'd256);
        chk16("frame_cnt wrap", {8'h00, frame_cnt}, 16'h0000);

        // en dropped mid-line for 5 cycles
        pattern_sel = 2'd0;
        reset_dut();
        run_model(HT + 3);
        held = mfcnt;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge llc);
            @(negedge llc);
            chk1($sformatf("en0 HREF c%0d", i), HREF, 1'b0);
            chk1($sformatf("en0 VREF c%0d", i), VREF, 1'b0);
            chk16($sformatf("en0 VPO c%0d", i), VPO, 16'h0000);
            chk1($sformatf("en0 frame_start c%0d", i), frame_start, 1'b0);
            chk16($sformatf("en0 frame_cnt c%0d", i), {8'h00, frame_cnt}, {8'h00, held});
        end
        en = 1'b1;
        @(posedge llc);
        @(negedge llc);
        chk1("en1 frame_start", frame_start, 1'b1);
        chk16("en1 frame_cnt", {8'h00, frame_cnt}, {8'h00, held + 8'd1});
        chk1("en1 HREF", HREF, 1'b1);
        chk16("en1 VPO", VPO, 16'hFFFF);
        mk    = 1;
        mfcnt = held + 8'd1;
        mpat  = pattern_sel;
        run_model(80);

        // reset asserted during an active pixel
        pattern_sel = 2'd3;
        solid_rgb   = 16'hABCD;
        reset_dut();
        run_model(5);
        rst = 1'b1;
        @(posedge llc);
        @(negedge llc);
        chk1("midrst HREF", HREF, 1'b0);
        chk1("midrst VREF", VREF, 1'b0);
        chk16("midrst VPO", VPO, 16'h0000);
        chk1("midrst frame_start", frame_start, 1'b0);
        chk16("midrst frame_cnt", {8'h00, frame_cnt}, 16'h0000);
        rst   = 1'b0;
        mk    = 0;
        mfcnt = 8'h00;
        run_model(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
